transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/tx_pkg.sv | 23 ++
 rtl/tx_fifo.sv | 63 ++++++
 rtl/transmitter.sv | 103 ++++++++++
 tb/tb_transmitter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared constants, FSM state type and baud helper for the serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_pkg;

  localparam int DATA_W        = 8;
  localparam int FIFO_DEPTH    = 16;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Terminal count of the baud counter; a divisor of 0 behaves like 1.
  function automatic logic [15:0] baud_period_m1(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Generic synchronous FIFO with registered full flag and wrapping pointers.
// Latency: a push is visible on dout (empty low) the edge after it is written.
// Backpressure: pushes while full are dropped, even if a pop happens that cycle.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ALMOST_FULL = (AW + 1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full is decided before the pop, so a write to a full FIFO never lands
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array: written only on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == ALMOST_FULL);
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// 8N1 serial transmitter: FIFO-buffered characters sent LSB-first at 16 ticks/bit.
// Latency: start bit drives tx on the edge after the character is enqueued.
// Backpressure: full is raised at FIFO_DEPTH entries; writes while full are dropped.
module transmitter #(
  parameter int DATA_W     = tx_pkg::DATA_W,
  parameter int FIFO_DEPTH = tx_pkg::FIFO_DEPTH
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D,
  input  logic [15:0]       divisor,
  input  logic              write,
  output logic              full,
  output logic              tx
);

  import tx_pkg::*;

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [3:0]       LAST_TICK = 4'(TICKS_PER_BIT - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] head;
  logic [BIT_W-1:0]  bit_cnt;
  logic [3:0]        tick_cnt;
  logic [15:0]       baud_cnt;
  logic [15:0]       div_q;
  logic              tick;
  logic              bit_end;
  logic              pop;
  logic              empty;

  tx_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (sclk),
    .rst  (rst),
    .push (write),
    .pop  (pop),
    .din  (D),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // Baud tick uses the divisor captured at frame start, so mid-frame changes wait
  assign tick    = (baud_cnt == baud_period_m1(div_q));
  assign bit_end = tick && (tick_cnt == LAST_TICK);
  // A new frame starts from IDLE, or straight out of a finished stop bit
  assign pop     = ~empty && ((state == IDLE) || ((state == STOP) && bit_end));

  // Frame sequencer: baud/tick/bit counters, shift register and registered tx
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      tick_cnt <= '0;
      baud_cnt <= '0;
      div_q    <= '0;
    end else if (pop) begin
      state    <= START;
      tx       <= 1'b0;
      shreg    <= head;
      div_q    <= divisor;
      bit_cnt  <= '0;
      tick_cnt <= '0;
      baud_cnt <= '0;
    end else if (state != IDLE) begin
      baud_cnt <= tick ? 16'd0 : baud_cnt + 16'd1;
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          // Stop bit done and nothing queued: line rests high
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Randomized bench for the serial transmitter against a timeline reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_transmitter;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          sclk = 1'b0;
  logic          rst;
  logic [DW-1:0] D;
  logic [15:0]   divisor;
  logic          write;
  logic          full;
  logic          tx;

  transmitter #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sclk   (sclk),
    .rst    (rst),
    .D      (D),
    .divisor(divisor),
    .write  (write),
    .full   (full),
    .tx     (tx)
  );

  always #5 sclk = ~sclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued characters plus the frame currently on the line,
  // described by its start cycle, bit time and payload.
  logic [DW-1:0] mq[$];
  bit            act    = 1'b0;
  int unsigned   cyc    = 0;
  int unsigned   fstart = 0;
  int unsigned   fbt    = 16;
  logic [DW-1:0] fbyte  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    act = 1'b0;
  endtask

  // One rising edge of the line: finish/start frames, then accept a write
  task automatic model_edge();
    int sz;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    sz = mq.size();
    if (act && (cyc - fstart) == 10 * fbt) act = 1'b0;
    if (!act && sz > 0) begin
      act    = 1'b1;
      fstart = cyc;
      fbyte  = mq.pop_front();
      fbt    = 16 * ((divisor == 16'd0) ? 1 : int'(divisor));
    end
    if (write && sz < DEPTH) mq.push_back(D);
  endtask

  function automatic logic exp_tx();
    int unsigned idx;
    if (!act) return 1'b1;
    idx = (cyc - fstart) / fbt;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return fbyte[idx-1];
    return 1'b1;
  endfunction

  task automatic step(input bit w, input logic [DW-1:0] d);
    write = w;
    D     = d;
    @(posedge sclk);
    model_edge();
    #1;
    check("tx", 32'(tx), 32'(exp_tx()));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    write   = 1'b0;
    D       = '0;
    divisor = 16'd1;
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    idle(3);
    rst = 1'b0;

    // Quiet line after reset
    idle(1000);

    // Single 0x55 at divisor 1
    step(1'b1, 8'h55);
    idle(200);

    // Fill past capacity, then drain
    for (int i = 0; i < 25; i++) step(1'b1, DW'($urandom));
    idle(17 * 160 + 50);

    // Back-to-back A3 then 0F
    step(1'b1, 8'hA3);
    step(1'b1, 8'h0F);
    idle(340);

    // divisor 0 and divisor 3 bit times
    divisor = 16'd0;
    step(1'b1, 8'hC6);
    idle(170);
    divisor = 16'd3;
    step(1'b1, 8'h39);
    idle(490);

    // Divisor change mid-frame only affects the following frame
    divisor = 16'd2;
    step(1'b1, 8'h81);
    step(1'b1, 8'h7E);
    idle(100);
    divisor = 16'd5;
    idle(320 + 800 + 50);

    // Randomized traffic with a wandering divisor
    for (int i = 0; i < 3000; i++) begin
      divisor = 16'($urandom_range(0, 3));
      step(($urandom_range(0, 3) == 0), DW'($urandom));
    end
    divisor = 16'd1;
    idle(17 * 480 + 50);

    // Reset during data bit 3 with a full FIFO
    for (int i = 0; i < 17; i++) step(1'b1, DW'($urandom));
    idle(50);
    check("pre_rst_full", 32'(full), 32'd1);
    rst = 1'b1;
    #2;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_full", 32'(full), 32'd0);
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
